// File: rtl/bus_slave_if_pkg.sv
// Shared types and constants for the bus_slave_if responder and its timer.
// The optional ACCESS watchdog is selected by the BUS_SLAVE_TIMEOUT_EN macro.
package bus_slave_if_pkg;

  localparam int WORD_DATA_W = 32;
  localparam int WORD_ADDR_W = 30;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int WAIT_CNT_W      = 4;
  localparam int TMO_CNT_W       = 8;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    BUS_SLAVE_STATE_IDLE   = 2'd0,
    BUS_SLAVE_STATE_ACCESS = 2'd1,
    BUS_SLAVE_STATE_WAIT   = 2'd2,
    BUS_SLAVE_STATE_READY  = 2'd3
  } state_e;

endpackage

// File: rtl/bus_slave_if_if.sv
// Bus-side and device-side signal bundle of bus_slave_if.
interface bus_slave_if_if #(
  parameter int DEV_ADDR_W = 12
);

  // Handshakes: a bus access is a one-cycle s_as_ low while s_cs_ is low; the slave answers with
  // exactly one cycle of s_rdy_ low. On the device side dev_req is a level held until dev_ack is seen high.
  logic                                     s_cs_;
  logic                                     s_as_;
  logic                                     s_rw;
  logic [bus_slave_if_pkg::WORD_ADDR_W-1:0] s_addr;
  logic [bus_slave_if_pkg::WORD_DATA_W-1:0] s_wr_data;
  logic [bus_slave_if_pkg::WORD_DATA_W-1:0] s_rd_data;
  logic                                     s_rdy_;
  logic                                     s_tmo;

  logic                                     dev_req;
  logic [DEV_ADDR_W-1:0]                    dev_addr;
  logic                                     dev_rw;
  logic [bus_slave_if_pkg::WORD_DATA_W-1:0] dev_wr_data;
  logic [bus_slave_if_pkg::WORD_DATA_W-1:0] dev_rd_data;
  logic                                     dev_ack;

  modport slave (
    input  s_cs_, s_as_, s_rw, s_addr, s_wr_data, dev_rd_data, dev_ack,
    output s_rd_data, s_rdy_, s_tmo, dev_req, dev_addr, dev_rw, dev_wr_data
  );

  modport master (
    output s_cs_, s_as_, s_rw, s_addr, s_wr_data, dev_rd_data, dev_ack,
    input  s_rd_data, s_rdy_, s_tmo, dev_req, dev_addr, dev_rw, dev_wr_data
  );

endinterface

// File: rtl/bus_slave_timer.sv
// Wait-state down-counter and, when BUS_SLAVE_TIMEOUT_EN is defined, the ACCESS watchdog counter.
module bus_slave_timer
  import bus_slave_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wait_load_i,
  input  logic [WAIT_CNT_W-1:0] wait_load_val_i,
  input  logic                  wait_en_i,
  output logic                  wait_zero_o,
  input  logic                  tmo_clr_i,
  input  logic                  tmo_en_i,
  output logic                  tmo_expired_o
);

  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (wait_load_i) wait_cnt_d = wait_load_val_i;
    else if (wait_en_i && wait_cnt_q != '0) wait_cnt_d = wait_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end

  assign wait_zero_o = (wait_cnt_q == '0);

`ifdef BUS_SLAVE_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (tmo_clr_i) tmo_cnt_d = '0;
    else if (tmo_en_i) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end

  // Raised during the last permitted ACCESS cycle, so an ack in that same cycle still wins.
  assign tmo_expired_o = tmo_en_i && (tmo_cnt_q == TMO_LAST);
`else
  wire unused_tmo = &{1'b0, tmo_clr_i, tmo_en_i, (TIMEOUT_CYCLES != 0)};
  assign tmo_expired_o = 1'b0;
`endif

endmodule

// File: rtl/bus_slave_if.sv
// Responder front-end for one bus slave: strobe capture, device req/ack, wait states, one-cycle ready.
// Optional ACCESS watchdog selected by BUS_SLAVE_TIMEOUT_EN.
module bus_slave_if
  import bus_slave_if_pkg::*;
#(
  parameter int DEV_ADDR_W     = 12,
  parameter int WAIT_CYCLES    = 0,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  bus_slave_if_if.slave bus,
  output state_e        dbg_state_o
);

  localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = HAS_WAIT ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e                  state_q, state_d;
  logic                    dev_req_q, dev_req_d;
  logic [DEV_ADDR_W-1:0]   dev_addr_q, dev_addr_d;
  logic                    dev_rw_q, dev_rw_d;
  logic [WORD_DATA_W-1:0]  dev_wr_data_q, dev_wr_data_d;
  logic [WORD_DATA_W-1:0]  rd_buf_q, rd_buf_d;
  logic                    tmo_q, tmo_d;
  logic                    wait_load, wait_en, wait_zero;
  logic                    tmo_clr, tmo_en, tmo_expired;

  bus_slave_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk             (clk),
    .reset           (reset),
    .wait_load_i     (wait_load),
    .wait_load_val_i (WAIT_LOAD),
    .wait_en_i       (wait_en),
    .wait_zero_o     (wait_zero),
    .tmo_clr_i       (tmo_clr),
    .tmo_en_i        (tmo_en),
    .tmo_expired_o   (tmo_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BUS_SLAVE_STATE_IDLE;
      dev_req_q     <= 1'b0;
      dev_addr_q    <= '0;
      dev_rw_q      <= READ;
      dev_wr_data_q <= '0;
      rd_buf_q      <= '0;
      tmo_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      dev_req_q     <= dev_req_d;
      dev_addr_q    <= dev_addr_d;
      dev_rw_q      <= dev_rw_d;
      dev_wr_data_q <= dev_wr_data_d;
      rd_buf_q      <= rd_buf_d;
      tmo_q         <= tmo_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    dev_req_d     = dev_req_q;
    dev_addr_d    = dev_addr_q;
    dev_rw_d      = dev_rw_q;
    dev_wr_data_d = dev_wr_data_q;
    rd_buf_d      = rd_buf_q;
    tmo_d         = tmo_q;
    wait_load     = 1'b0;
    wait_en       = 1'b0;
    tmo_clr       = 1'b0;
    tmo_en        = 1'b0;
    case (state_q)
      BUS_SLAVE_STATE_IDLE: begin
        tmo_clr = 1'b1;
        if (bus.s_cs_ == ENABLE_ && bus.s_as_ == ENABLE_) begin
          dev_req_d     = 1'b1;
          dev_addr_d    = bus.s_addr[DEV_ADDR_W-1:0];
          dev_rw_d      = bus.s_rw;
          dev_wr_data_d = bus.s_wr_data;
          state_d       = BUS_SLAVE_STATE_ACCESS;
        end
      end
      BUS_SLAVE_STATE_ACCESS: begin
        tmo_en = 1'b1;
        if (bus.dev_ack) begin
          dev_req_d = 1'b0;
          rd_buf_d  = (dev_rw_q == READ) ? bus.dev_rd_data : '0;
          if (HAS_WAIT) begin
            wait_load = 1'b1;
            state_d   = BUS_SLAVE_STATE_WAIT;
          end else begin
            state_d   = BUS_SLAVE_STATE_READY;
          end
        end else if (tmo_expired) begin
          dev_req_d = 1'b0;
          rd_buf_d  = '0;
          tmo_d     = 1'b1;
          state_d   = BUS_SLAVE_STATE_READY;
        end
      end
      BUS_SLAVE_STATE_WAIT: begin
        wait_en = 1'b1;
        if (wait_zero) state_d = BUS_SLAVE_STATE_READY;
      end
      BUS_SLAVE_STATE_READY: begin
        dev_addr_d    = '0;
        dev_rw_d      = WRITE;
        dev_wr_data_d = '0;
        tmo_d         = 1'b0;
        state_d       = BUS_SLAVE_STATE_IDLE;
      end
      default: state_d = BUS_SLAVE_STATE_IDLE;
    endcase
  end

  // rd_buf is already zero for writes and timeouts, so the read-data mux only needs the state.
  assign bus.s_rdy_      = (state_q == BUS_SLAVE_STATE_READY) ? ENABLE_ : DISABLE_;
  assign bus.s_rd_data   = (state_q == BUS_SLAVE_STATE_READY) ? rd_buf_q : '0;
  assign bus.s_tmo       = tmo_q;
  assign bus.dev_req     = dev_req_q;
  assign bus.dev_addr    = dev_addr_q;
  assign bus.dev_rw      = dev_rw_q;
  assign bus.dev_wr_data = dev_wr_data_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_bus_slave_if.sv
// Bench for bus_slave_if: two instances (no wait states and three wait states) share one bus driver;
// each has its own device responder and ready scoreboard. Timeout cases apply with BUS_SLAVE_TIMEOUT_EN.
module tb_bus_slave_if;
  import bus_slave_if_pkg::*;

  localparam int DEV_ADDR_W = 12;
  localparam int W0  = 0;
  localparam int W1  = 3;
  localparam int TMO = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  bus_slave_if_if #(.DEV_ADDR_W(DEV_ADDR_W)) bus0();
  bus_slave_if_if #(.DEV_ADDR_W(DEV_ADDR_W)) bus1();
  state_e dbg0, dbg1;

  bus_slave_if #(.DEV_ADDR_W(DEV_ADDR_W), .WAIT_CYCLES(W0), .TIMEOUT_CYCLES(TMO)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .dbg_state_o(dbg0));
  bus_slave_if #(.DEV_ADDR_W(DEV_ADDR_W), .WAIT_CYCLES(W1), .TIMEOUT_CYCLES(TMO)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .dbg_state_o(dbg1));

  // Shared bus stimulus
  logic        cs_n  = 1'b1;
  logic        as_n  = 1'b1;
  logic        rw    = READ;
  logic [29:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata = '0;
  int          ack_dly = 0;

  assign bus0.s_cs_ = cs_n;      assign bus1.s_cs_ = cs_n;
  assign bus0.s_as_ = as_n;      assign bus1.s_as_ = as_n;
  assign bus0.s_rw = rw;         assign bus1.s_rw = rw;
  assign bus0.s_addr = addr;     assign bus1.s_addr = addr;
  assign bus0.s_wr_data = wdata; assign bus1.s_wr_data = wdata;
  assign bus0.dev_rd_data = rdata;
  assign bus1.dev_rd_data = rdata;

  // Device responders: ack (combinationally) once dev_req has been high for ack_dly full cycles.
  int acnt0 = 0, acnt1 = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      acnt0 <= 0;
      acnt1 <= 0;
    end else begin
      acnt0 <= bus0.dev_req ? acnt0 + 1 : 0;
      acnt1 <= bus1.dev_req ? acnt1 + 1 : 0;
    end
  end
  assign bus0.dev_ack = bus0.dev_req && (acnt0 >= ack_dly);
  assign bus1.dev_ack = bus1.dev_req && (acnt1 >= ack_dly);

  // ---------------- scoreboard ----------------
  // Entry layout: {ready cycle[31:0], tmo, read data[31:0]}
  logic [64:0] exp_q0[$];
  logic [64:0] exp_q1[$];
  logic [11:0] e_addr  = '0;
  logic        e_rw    = READ;
  logic [31:0] e_wdata = '0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: the device is busy for dly+1 cycles (or the watchdog limit), then the configured
  // wait states elapse, then one ready cycle. ts is the cycle number of the first request cycle.
  function automatic logic [64:0] model(input int ts, input int w, input logic rw_v,
                                        input logic [31:0] rd, input int dly);
    int          a;
    logic        tmo;
    logic [31:0] d;
    a   = dly + 1;
    tmo = 1'b0;
    d   = (rw_v == READ) ? rd : 32'h0;
`ifdef BUS_SLAVE_TIMEOUT_EN
    if (a > TMO) begin
      a   = TMO;
      tmo = 1'b1;
      d   = 32'h0;
    end
`endif
    return {32'(ts + a + (tmo ? 0 : w)), tmo, d};
  endfunction

  task automatic mon(input int k, input logic rdy_n, input logic [31:0] rd, input logic tmo);
    logic [64:0] e;
    int          sz;
    sz = (k == 0) ? exp_q0.size() : exp_q1.size();
    if (!rdy_n) begin
      chk($sformatf("rdy_pending%0d", k), 64'(sz != 0), 64'd1);
      if (sz != 0) begin
        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk($sformatf("rdy_cycle%0d", k), 64'(cyc), 64'(e[64:33]));
        chk($sformatf("rd_data%0d", k), 64'(rd), 64'(e[31:0]));
        chk($sformatf("tmo%0d", k), 64'(tmo), 64'(e[32]));
      end
    end else begin
      chk($sformatf("idle_rd_data%0d", k), 64'(rd), 64'd0);
      chk($sformatf("idle_tmo%0d", k), 64'(tmo), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mon(0, bus0.s_rdy_, bus0.s_rd_data, bus0.s_tmo);
      mon(1, bus1.s_rdy_, bus1.s_rd_data, bus1.s_tmo);
    end
  end

  // Latched request fields must hold for as long as dev_req is high.
  always @(negedge clk) begin
    if (reset && bus0.dev_req) begin
      chk("dev_addr0", 64'(bus0.dev_addr), 64'(e_addr));
      chk("dev_rw0", 64'(bus0.dev_rw), 64'(e_rw));
      chk("dev_wr_data0", 64'(bus0.dev_wr_data), 64'(e_wdata));
    end
    if (reset && bus1.dev_req) begin
      chk("dev_addr1", 64'(bus1.dev_addr), 64'(e_addr));
      chk("dev_rw1", 64'(bus1.dev_rw), 64'(e_rw));
      chk("dev_wr_data1", 64'(bus1.dev_wr_data), 64'(e_wdata));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_access(input logic cs_v, input logic rw_v, input logic [29:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int dly);
    @(negedge clk);
    cs_n = cs_v; as_n = 1'b0; rw = rw_v; addr = a; wdata = wd;
    if (!cs_v) begin
      rdata = rd; ack_dly = dly;
      e_addr = a[11:0]; e_rw = rw_v; e_wdata = wd;
      exp_q0.push_back(model(cyc + 1, W0, rw_v, rd, dly));
      exp_q1.push_back(model(cyc + 1, W1, rw_v, rd, dly));
    end
    @(negedge clk);
    // Scramble the bus after the strobe to prove the request fields were latched.
    as_n = 1'b1; cs_n = 1'b1; rw = 1'($urandom_range(0, 1)); addr = 30'($urandom); wdata = $urandom;
    if (cs_v) begin
      chk("nosel_dev_req0", 64'(bus0.dev_req), 64'd0);
      chk("nosel_dev_req1", 64'(bus1.dev_req), 64'd0);
      chk("nosel_state0", 64'(dbg0), 64'(BUS_SLAVE_STATE_IDLE));
      chk("nosel_state1", 64'(dbg1), 64'(BUS_SLAVE_STATE_IDLE));
    end
  endtask

  task automatic stray_strobe();
    @(negedge clk);
    cs_n = 1'b0; as_n = 1'b0; rw = ~e_rw; addr = 30'($urandom); wdata = $urandom;
    @(negedge clk);
    as_n = 1'b1; cs_n = 1'b1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_in_time", 64'(n < 300), 64'd1);
    if (n >= 300) begin
      exp_q0.delete();
      exp_q1.delete();
    end
  endtask

  task automatic idle_cleared();
    @(negedge clk);
    chk("clr_dev_req0", 64'(bus0.dev_req), 64'd0);
    chk("clr_dev_addr0", 64'(bus0.dev_addr), 64'd0);
    chk("clr_dev_rw0", 64'(bus0.dev_rw), 64'(WRITE));
    chk("clr_dev_wr_data0", 64'(bus0.dev_wr_data), 64'd0);
    chk("clr_dev_req1", 64'(bus1.dev_req), 64'd0);
    chk("clr_dev_addr1", 64'(bus1.dev_addr), 64'd0);
    chk("clr_dev_rw1", 64'(bus1.dev_rw), 64'(WRITE));
    chk("clr_dev_wr_data1", 64'(bus1.dev_wr_data), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic cs_v;
    int   dly;

    repeat (3) @(negedge clk);
    chk("rst_rdy", 64'({bus0.s_rdy_, bus1.s_rdy_}), 64'b11);
    chk("rst_rd_data", 64'(bus0.s_rd_data | bus1.s_rd_data), 64'd0);
    chk("rst_tmo", 64'({bus0.s_tmo, bus1.s_tmo}), 64'd0);
    chk("rst_dev_req", 64'({bus0.dev_req, bus1.dev_req}), 64'd0);
    chk("rst_dev_addr", 64'(bus0.dev_addr | bus1.dev_addr), 64'd0);
    chk("rst_dev_rw", 64'({bus0.dev_rw, bus1.dev_rw}), 64'({READ, READ}));
    chk("rst_dev_wr_data", 64'(bus0.dev_wr_data | bus1.dev_wr_data), 64'd0);
    chk("rst_state0", 64'(dbg0), 64'(BUS_SLAVE_STATE_IDLE));
    chk("rst_state1", 64'(dbg1), 64'(BUS_SLAVE_STATE_IDLE));
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Directed read with immediate ack, then write with a four-cycle device access.
    do_access(1'b0, READ, 30'h0000_0123, 32'h0, 32'hCAFE_0001, 0);
    wait_done();
    do_access(1'b0, WRITE, 30'h0000_0456, 32'h1234_5678, 32'hFFFF_FFFF, 3);
    wait_done();
    idle_cleared();

    // Strobe without chip select.
    do_access(1'b1, READ, 30'h0000_0789, 32'h0, 32'h0, 0);

    // Second strobe during ACCESS must be ignored.
    do_access(1'b0, READ, 30'h0ABC_D321, 32'h0, 32'h5A5A_1234, 4);
    stray_strobe();
    wait_done();

    // Watchdog boundary: no ack at all, and an ack in the last permitted cycle.
    do_access(1'b0, READ, 30'h0000_0F0F, 32'h0, 32'hDEAD_0001, 20);
    wait_done();
    do_access(1'b0, READ, 30'h0000_00F0, 32'h0, 32'hBEEF_0008, TMO - 1);
    wait_done();

    // Randomized back-to-back traffic.
    for (int i = 0; i < 40; i++) begin
      cs_v = ($urandom_range(0, 7) == 0);
      dly  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(7, 12)) : int'($urandom_range(0, 5));
      do_access(cs_v, 1'($urandom_range(0, 1)), 30'($urandom), $urandom, $urandom, dly);
      if (!cs_v) wait_done();
    end

    // Reset in the middle of an access: request drops at once, no ready afterwards.
    do_access(1'b0, READ, 30'h0000_0055, 32'h0, 32'hDEAD_BEEF, 6);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_dev_req0", 64'(bus0.dev_req), 64'd0);
    chk("arst_dev_req1", 64'(bus1.dev_req), 64'd0);
    chk("arst_state0", 64'(dbg0), 64'(BUS_SLAVE_STATE_IDLE));
    chk("arst_state1", 64'(dbg1), 64'(BUS_SLAVE_STATE_IDLE));
    chk("arst_dev_addr", 64'(bus0.dev_addr | bus1.dev_addr), 64'd0);
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
